modmul_interleaved: RTL and testbench
=====================================

# modmul_interleaved

Parametrised successor to the 64-bit modular multiplier for the ElGamal datapath: computes (A·B) mod M for WIDTH-bit operands by MSB-first interleaved shift-add-reduce, one multiplier bit per cycle. It adds a square mode, where B = A and no multiplicand beat is consumed. It also adds operand range checking with an error flag. It sits between the key/ciphertext stream sources and the modular-exponentiation sequencer, using the same valid/ready stream handshakes.

## Interface
- WIDTH, 64: operand and modulus width in bits; legal range ≥ 4.
- CNT_W, $clog2(WIDTH): iteration counter width (derived, not overridden).

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- input_multiplier_tdata  in  WIDTH  operand A.
- input_multiplier_tuser  in  1  mode: 1 = square (B := A), 0 = multiply.
- input_multiplier_tvalid / _tready  in / out  1  A handshake.
- input_multiplicand_tdata  in  WIDTH  operand B.
- input_multiplicand_tvalid / _tready  in / out  1  B handshake.
- input_modulus_tdata  in  WIDTH  modulus M.
- input_modulus_tvalid / _tready  in / out  1  M handshake.
- output_tdata  out  WIDTH  result; 0 when error.
- output_tuser  out  1  error flag.
- output_tvalid  out  1  result valid.
- output_tready  in  1  downstream accept.

## Operation
- States: COLLECT, RUN, DONE.
- COLLECT:
  - Each stream's tready = 1 while its operand is not yet captured.
  - Streams are captured independently, in any order or together.
  - Multiplicand tready stays 0 once A has been captured with tuser = 1.
  - Mode is latched with A.
- Completion: when the last required operand is captured, the range check runs on the capture values.
  - Error if M < 2, A ≥ M, or B_eff ≥ M.
  - Error → DONE, with output_tdata = 0 and output_tuser = 1.
  - Otherwise → RUN, with P = 0 and counter = WIDTH−1.
- RUN, each cycle with i = counter:
  - P ← 2P.
  - If A[i] = 1: P ← P + B_eff.
  - If P ≥ M: P ← P − M. Repeat once more if still ≥ M.
  - Intermediates are WIDTH+2 bits wide; the result always satisfies P < M.
  - When counter = 0 → DONE, with output_tdata = P[WIDTH−1:0] and tuser = 0.
- DONE:
  - output_tvalid = 1. tdata and tuser are held stable until the handshake.
  - On output_tvalid & output_tready → COLLECT, and all captured flags are cleared.
- No input tready is asserted outside COLLECT. Operands are never accepted early for the next job.

## Timing
- Reset values: all tready = 0, output_tvalid = 0, output_tdata = 0, output_tuser = 0, state = COLLECT, captured flags cleared.
- In the first cycle after rst deasserts, the input treadies rise.
- Latency, normal case: output_tvalid rises exactly WIDTH+1 edges after the edge that captured the final operand (1 capture edge + WIDTH iterations).
- Latency, error case: output_tvalid rises 1 edge after the final capture.
- Throughput: one result per WIDTH+2 cycles with output_tready held at 1.
- Backpressure: output_tready = 0 in DONE holds the output indefinitely. No iteration or capture happens meanwhile.
- tready depends only on state and captured flags, never combinationally on tvalid.
- rst mid-RUN or mid-DONE: the job is discarded with no output beat, and all registers return to their reset values in the same edge.
- Simultaneous capture of all three streams on one edge is legal and counts as completion on that edge.

## Structure
- Package modmul_pkg:
  - state enum {COLLECT, RUN, DONE}.
  - localparam error-code bit position.
  - Helper function for the guard width (WIDTH+2).
- Sub-module modmul_step: purely combinational single iteration.
  - Inputs: P, B_eff, M, bit.
  - Function: double, conditional add, two conditional subtracts.
  - Output: next P.
  - Instantiated once; lets the bench check it exhaustively at WIDTH = 4.

## Test plan
- WIDTH = 64, A = B = 9223372036854775337, M = 9223372036854775433, multiply mode, output_tready = 1 → output_tdata = 9216, tuser = 0, tvalid exactly 65 edges after the last capture.
- Same A and M in square mode, multiplicand tvalid held at 0 → same result 9216; multiplicand tready never asserted after A is captured.
- WIDTH = 8, A = 200, B = 100, M = 251 → output_tdata = 171. The modulus beat arrives 5 cycles after A and B; latency is counted from the modulus beat.
- WIDTH = 8, M = 1, or A = 251 with M = 251 → tvalid 1 edge after capture, output_tdata = 0, tuser = 1.
- Hold output_tready = 0 for 10 cycles in DONE → tdata and tuser stable, all input treadies stay 0; accept on cycle 11, and treadies return next cycle.
- Assert rst for 1 cycle mid-RUN → no output beat, outputs at reset values. A new job (A = 3, B = 5, M = 7 at WIDTH = 8) then yields 1.

Source files
------------

// File: rtl/modmul_pkg.sv
// rtl/modmul_pkg.sv - shared types and helpers for the interleaved modular multiplier
// Contents: controller state enum, error bit position in the status word,
// guard-width helper for the WIDTH+2 bit intermediate datapath.
package modmul_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    RUN,
    DONE
  } state_t;

  // Position of the range-check error flag inside the registered status word.
  localparam int ERR_BIT = 0;

  // Doubling plus one addend of < M needs two guard bits above WIDTH.
  function automatic int guard_width(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/modmul_step.sv
// rtl/modmul_step.sv - one combinational MSB-first shift-add-reduce iteration
// Ports:
//   p      in  WIDTH  running partial result, must be < m
//   b_eff  in  WIDTH  multiplicand (or A in square mode), must be < m
//   m      in  WIDTH  modulus
//   mbit   in  1      current multiplier bit
//   p_next out WIDTH  (2*p + mbit*b_eff) mod m
module modmul_step
  import modmul_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] b_eff,
  input  logic [WIDTH-1:0] m,
  input  logic             mbit,
  output logic [WIDTH-1:0] p_next
);

  localparam int GW = guard_width(WIDTH);

  logic [GW-1:0] dbl;
  logic [GW-1:0] sum;
  logic [GW-1:0] mx;
  logic [GW-1:0] sub1;

  // With p < m and b_eff < m the sum is below 3m, so two conditional
  // subtractions always land the result in [0, m).
  always_comb begin
    mx     = {2'b00, m};
    dbl    = {1'b0, p, 1'b0};
    sum    = dbl + (mbit ? {2'b00, b_eff} : GW'(0));
    sub1   = (sum >= mx) ? (sum - mx) : sum;
    p_next = (sub1 >= mx) ? WIDTH'(sub1 - mx) : sub1[WIDTH-1:0];
  end

endmodule

// File: rtl/modmul_interleaved.sv
// rtl/modmul_interleaved.sv - (A*B) mod M, one multiplier bit per cycle, with square mode
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   input_multiplier_*            operand A stream; tuser = 1 selects square (B := A)
//   input_multiplicand_*          operand B stream (not consumed in square mode)
//   input_modulus_*               modulus M stream
//   output_tdata/tuser/tvalid     result, error flag (result 0 on error), valid
//   output_tready                 downstream accept
module modmul_interleaved
  import modmul_pkg::*;
#(
  parameter  int WIDTH = 64,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_multiplier_tdata,
  input  logic             input_multiplier_tuser,
  input  logic             input_multiplier_tvalid,
  output logic             input_multiplier_tready,
  input  logic [WIDTH-1:0] input_multiplicand_tdata,
  input  logic             input_multiplicand_tvalid,
  output logic             input_multiplicand_tready,
  input  logic [WIDTH-1:0] input_modulus_tdata,
  input  logic             input_modulus_tvalid,
  output logic             input_modulus_tready,
  output logic [WIDTH-1:0] output_tdata,
  output logic             output_tuser,
  input  logic             output_tready,
  output logic             output_tvalid
);

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, m_q, p_q;
  logic             sq_q;
  logic             got_a, got_b, got_m;
  logic [CNT_W-1:0] cnt;
  logic [ERR_BIT:0] status_q;

  logic             fire_a, fire_b, fire_m;
  logic [WIDTH-1:0] a_v, b_v, m_v, beff_v, beff_run, p_next;
  logic             sq_v, got_a_n, got_b_n, got_m_n, complete, range_err;

  // Capture-side view: the operand values and flags as they will be after
  // this edge, so completion and the range check see same-edge captures.
  always_comb begin
    fire_a    = input_multiplier_tvalid & input_multiplier_tready;
    fire_b    = input_multiplicand_tvalid & input_multiplicand_tready;
    fire_m    = input_modulus_tvalid & input_modulus_tready;
    a_v       = fire_a ? input_multiplier_tdata : a_q;
    sq_v      = fire_a ? input_multiplier_tuser : sq_q;
    b_v       = fire_b ? input_multiplicand_tdata : b_q;
    m_v       = fire_m ? input_modulus_tdata : m_q;
    got_a_n   = got_a | fire_a;
    got_b_n   = got_b | fire_b;
    got_m_n   = got_m | fire_m;
    complete  = got_a_n & got_m_n & (got_b_n | sq_v);
    beff_v    = sq_v ? a_v : b_v;
    range_err = (m_v < WIDTH'(2)) | (a_v >= m_v) | (beff_v >= m_v);
    beff_run  = sq_q ? a_q : b_q;
  end

  modmul_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_q),
    .b_eff  (beff_run),
    .m      (m_q),
    .mbit   (a_q[cnt]),
    .p_next (p_next)
  );

  assign output_tuser = status_q[ERR_BIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= COLLECT;
      a_q                       <= '0;
      b_q                       <= '0;
      m_q                       <= '0;
      p_q                       <= '0;
      sq_q                      <= 1'b0;
      got_a                     <= 1'b0;
      got_b                     <= 1'b0;
      got_m                     <= 1'b0;
      cnt                       <= '0;
      status_q                  <= '0;
      output_tdata              <= '0;
      output_tvalid             <= 1'b0;
      input_multiplier_tready   <= 1'b0;
      input_multiplicand_tready <= 1'b0;
      input_modulus_tready      <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          a_q   <= a_v;
          b_q   <= b_v;
          m_q   <= m_v;
          sq_q  <= sq_v;
          got_a <= got_a_n;
          got_b <= got_b_n;
          got_m <= got_m_n;
          if (complete) begin
            input_multiplier_tready   <= 1'b0;
            input_multiplicand_tready <= 1'b0;
            input_modulus_tready      <= 1'b0;
            if (range_err) begin
              state             <= DONE;
              output_tdata      <= '0;
              status_q[ERR_BIT] <= 1'b1;
              output_tvalid     <= 1'b1;
            end else begin
              state <= RUN;
              p_q   <= '0;
              cnt   <= CNT_W'(WIDTH - 1);
            end
          end else begin
            input_multiplier_tready   <= ~got_a_n;
            // Square mode never consumes a multiplicand beat.
            input_multiplicand_tready <= ~got_b_n & ~(got_a_n & sq_v);
            input_modulus_tready      <= ~got_m_n;
          end
        end
        RUN: begin
          p_q <= p_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state             <= DONE;
            output_tdata      <= p_next;
            status_q[ERR_BIT] <= 1'b0;
            output_tvalid     <= 1'b1;
          end
        end
        DONE: begin
          if (output_tready) begin
            state                     <= COLLECT;
            output_tvalid             <= 1'b0;
            got_a                     <= 1'b0;
            got_b                     <= 1'b0;
            got_m                     <= 1'b0;
            input_multiplier_tready   <= 1'b1;
            input_multiplicand_tready <= 1'b1;
            input_modulus_tready      <= 1'b1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_modmul_interleaved.sv
// tb/tb_modmul_interleaved.sv - self-checking bench for modmul_interleaved and modmul_step
module tb_modmul_interleaved;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic [63:0] a_data = '0, b_data = '0, m_data = '0;
  logic        a_user = 1'b0, a_valid = 1'b0, b_valid = 1'b0, m_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        a_rdy64, b_rdy64, m_rdy64, ov64, ou64;
  logic [63:0] od64;
  logic        a_rdy8, b_rdy8, m_rdy8, ov8, ou8;
  logic [7:0]  od8;

  logic        a_ready, b_ready, m_ready, out_valid, out_user;
  logic [63:0] out_data;

  assign a_ready   = sel ? a_rdy8 : a_rdy64;
  assign b_ready   = sel ? b_rdy8 : b_rdy64;
  assign m_ready   = sel ? m_rdy8 : m_rdy64;
  assign out_valid = sel ? ov8 : ov64;
  assign out_user  = sel ? ou8 : ou64;
  assign out_data  = sel ? {56'b0, od8} : od64;

  modmul_interleaved #(.WIDTH(64)) u64 (
    .clk(clk), .rst(rst),
    .input_multiplier_tdata(a_data), .input_multiplier_tuser(a_user),
    .input_multiplier_tvalid(a_valid & ~sel), .input_multiplier_tready(a_rdy64),
    .input_multiplicand_tdata(b_data),
    .input_multiplicand_tvalid(b_valid & ~sel), .input_multiplicand_tready(b_rdy64),
    .input_modulus_tdata(m_data),
    .input_modulus_tvalid(m_valid & ~sel), .input_modulus_tready(m_rdy64),
    .output_tdata(od64), .output_tuser(ou64),
    .output_tready(out_ready & ~sel), .output_tvalid(ov64)
  );

  modmul_interleaved #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .input_multiplier_tdata(a_data[7:0]), .input_multiplier_tuser(a_user),
    .input_multiplier_tvalid(a_valid & sel), .input_multiplier_tready(a_rdy8),
    .input_multiplicand_tdata(b_data[7:0]),
    .input_multiplicand_tvalid(b_valid & sel), .input_multiplicand_tready(b_rdy8),
    .input_modulus_tdata(m_data[7:0]),
    .input_modulus_tvalid(m_valid & sel), .input_modulus_tready(m_rdy8),
    .output_tdata(od8), .output_tuser(ou8),
    .output_tready(out_ready & sel), .output_tvalid(ov8)
  );

  logic [3:0] sp = '0, sb = '0, sm = '0, sn;
  logic       sbit = 1'b0;

  modmul_step #(.WIDTH(4)) u_step (
    .p(sp), .b_eff(sb), .m(sm), .mbit(sbit), .p_next(sn)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One job: s selects the DUT (0: WIDTH 64, 1: WIDTH 8), mdelay delays the
  // modulus beat, bp holds output_tready low for that many cycles in DONE.
  task automatic job(input logic s, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] m, input logic sq, input int mdelay, input int bp);
    int w, n, cyc;
    logic ga, gb, gm, fa, fb, fm, err, any_rdy, stable, hold_u;
    logic [63:0] beff, exp, hold_d;
    logic [127:0] prod;
    sel  = s;
    w    = s ? 8 : 64;
    beff = sq ? a : b;
    err  = (m < 2) || (a >= m) || (beff >= m);
    exp  = '0;
    if (!err) begin
      prod = 128'(a) * 128'(beff);
      exp  = 64'(prod % 128'(m));
    end
    a_data = a; a_user = sq; b_data = b; m_data = m;
    a_valid = 1'b1; b_valid = ~sq; m_valid = 1'b0;
    out_ready = (bp == 0);
    ga = 1'b0; gb = sq; gm = 1'b0; cyc = 0;
    while (!(ga && gb && gm) && cyc < 100) begin
      if (cyc >= mdelay) m_valid = 1'b1;
      #1;
      fa = a_valid & a_ready; fb = b_valid & b_ready; fm = m_valid & m_ready;
      @(posedge clk); #1;
      if (fa) begin ga = 1'b1; a_valid = 1'b0; end
      if (fb) begin gb = 1'b1; b_valid = 1'b0; end
      if (fm) begin gm = 1'b1; m_valid = 1'b0; end
      if (sq && ga && !gm) check("sq_b_ready_low", b_ready, 0);
      cyc++;
    end
    a_valid = 1'b0; b_valid = 1'b0; m_valid = 1'b0;
    if (!(ga && gb && gm)) begin
      check("capture_timeout", 0, 1);
      return;
    end
    n = 1;
    any_rdy = a_ready | b_ready | m_ready;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
      any_rdy |= a_ready | b_ready | m_ready;
    end
    check("latency", n, err ? 1 : w + 1);
    check("result", out_data, exp);
    check("err_flag", out_user, err);
    hold_d = out_data; hold_u = out_user; stable = 1'b1;
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      stable &= out_valid && (out_data == hold_d) && (out_user == hold_u);
      any_rdy |= a_ready | b_ready | m_ready;
    end
    if (bp > 0) check("bp_hold", stable, 1);
    check("busy_ready_low", any_rdy, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("accept_valid_low", out_valid, 0);
    check("ready_return", {a_ready, b_ready, m_ready}, 3'b111);
  endtask

  localparam logic [63:0] A64 = 64'd9223372036854775337;
  localparam logic [63:0] M64 = 64'd9223372036854775433;

  initial begin
    logic        any_v;
    logic [63:0] ra, rb, rm;

    // Reset values on both instances.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      check("rst_ready", {a_ready, b_ready, m_ready}, 3'b000);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_user", out_user, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      check("post_rst_ready", {a_ready, b_ready, m_ready}, 3'b111);
    end

    // Directed jobs.
    job(1'b0, A64, A64, M64, 1'b0, 0, 0);
    job(1'b0, A64, 64'd0, M64, 1'b1, 3, 0);
    job(1'b1, 64'd200, 64'd100, 64'd251, 1'b0, 5, 0);
    job(1'b1, 64'd5, 64'd3, 64'd1, 1'b0, 0, 0);
    job(1'b1, 64'd251, 64'd3, 64'd251, 1'b0, 0, 0);
    job(1'b1, 64'd17, 64'd23, 64'd101, 1'b0, 0, 10);
    job(1'b1, 64'd250, 64'd0, 64'd251, 1'b1, 1, 1);

    // Reset in the middle of RUN discards the job.
    sel = 1'b1;
    a_data = 64'd200; b_data = 64'd100; m_data = 64'd251; a_user = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; m_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0; m_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrun_rst_valid", out_valid, 0);
    check("midrun_rst_data", out_data, 0);
    check("midrun_rst_ready", {a_ready, b_ready, m_ready}, 3'b000);
    rst = 1'b0;
    any_v = 1'b0;
    @(posedge clk); #1;
    check("midrun_ready_return", {a_ready, b_ready, m_ready}, 3'b111);
    for (int k = 0; k < 12; k++) begin
      any_v |= out_valid;
      @(posedge clk); #1;
    end
    check("midrun_no_beat", any_v, 0);
    job(1'b1, 64'd3, 64'd5, 64'd7, 1'b0, 0, 0);

    // Randomized jobs against the arithmetic model.
    for (int r = 0; r < 20; r++) begin
      rm = 64'($urandom_range(0, 255));
      ra = 64'($urandom_range(0, 255));
      rb = 64'($urandom_range(0, 255));
      if (rm > 1 && $urandom_range(0, 3) != 0) begin
        ra = ra % rm;
        rb = rb % rm;
      end
      job(1'b1, ra, rb, rm, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2));
    end
    for (int r = 0; r < 4; r++) begin
      rm = {1'b1, 31'($urandom), 32'($urandom)};
      ra = {32'($urandom), 32'($urandom)} % rm;
      rb = {32'($urandom), 32'($urandom)} % rm;
      job(1'b0, ra, rb, rm, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 1));
    end

    // Exhaustive single-step check at WIDTH 4 over the legal domain.
    for (int m = 2; m < 16; m++)
      for (int p = 0; p < m; p++)
        for (int b = 0; b < m; b++)
          for (int t = 0; t < 2; t++) begin
            sp = 4'(p); sb = 4'(b); sm = 4'(m); sbit = t[0];
            #1;
            check("step4", 64'(sn), 64'((2 * p + t * b) % m));
          end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
